// File: rtl/rf_write_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// rf_write_sequencer_pkg
// Shared definitions for the register-file write sequencer and the register
// file it feeds: the sequencer state encoding and the default geometry of the
// architectural register file.
// ---------------------------------------------------------------------------
package rf_write_sequencer_pkg;

  // Default register-file geometry shared with the register file itself.
  localparam int RF_NUM_REGS     = 15;
  localparam int RF_DATA_W       = 32;
  localparam int RF_ADDR_W       = 4;
  localparam int RF_STARVE_LIMIT = 8;

  // SCRUB: post-reset sweep writing i to register i, pipeline held.
  // RUN:   normal operation, writeback has priority over debug.
  typedef enum logic [0:0] {
    SCRUB = 1'b0,
    RUN   = 1'b1
  } rf_seq_state_e;

endpackage : rf_write_sequencer_pkg

// File: rtl/rf_write_sequencer_if.sv
// ---------------------------------------------------------------------------
// rf_write_sequencer_if
// Bundles the writeback request, debug request/handshake, register-file write
// port and status signals of rf_write_sequencer.
//   master : requester / observer side (drives wb_* and dbg_* requests)
//   slave  : sequencer side (drives dbg_ready, rf_*, busy, freeze,
//            wb_drop_err)
// ---------------------------------------------------------------------------
interface rf_write_sequencer_if
  import rf_write_sequencer_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DATA_W = RF_DATA_W
) ();

  // Writeback-stage request (no handshake, always accepted in RUN)
  logic              wb_en;
  logic [ADDR_W-1:0] wb_dest;
  logic [DATA_W-1:0] wb_val;

  // Debug/loader request with valid/ready handshake
  logic              dbg_valid;
  logic [ADDR_W-1:0] dbg_dest;
  logic [DATA_W-1:0] dbg_val;
  logic              dbg_ready;

  // Register-file write port
  logic              rf_we;
  logic [ADDR_W-1:0] rf_dest;
  logic [DATA_W-1:0] rf_val;

  // Status
  logic              busy;
  logic              freeze;
  logic              wb_drop_err;

  modport master (
    output wb_en, wb_dest, wb_val,
    output dbg_valid, dbg_dest, dbg_val,
    input  dbg_ready,
    input  rf_we, rf_dest, rf_val,
    input  busy, freeze, wb_drop_err
  );

  modport slave (
    input  wb_en, wb_dest, wb_val,
    input  dbg_valid, dbg_dest, dbg_val,
    output dbg_ready,
    output rf_we, rf_dest, rf_val,
    output busy, freeze, wb_drop_err
  );

endinterface : rf_write_sequencer_if

// File: rtl/rf_write_sequencer_starve_counter.sv
// ---------------------------------------------------------------------------
// starve_counter
// Counts consecutive cycles a debug request has been waiting and raises a
// registered saturation flag once the count reaches LIMIT.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   inc        : debug request waited this cycle
//   clr        : debug transferred or withdrew this cycle (wins over inc)
//   saturated  : registered, 1 while the count equals LIMIT
// ---------------------------------------------------------------------------
module starve_counter #(
  parameter int LIMIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic saturated
);

  localparam int CNT_W = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;

  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic             sat_reg;

  always_comb begin
    count_next = count_reg;
    if (clr) begin
      count_next = '0;
    end else if (inc && (count_reg != CNT_W'(LIMIT))) begin
      count_next = count_reg + CNT_W'(1);
    end
  end

  // The flag is computed from the next count so it rises on the same edge
  // the counter reaches LIMIT and falls on the edge the counter clears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
      sat_reg   <= 1'b0;
    end else begin
      count_reg <= count_next;
      sat_reg   <= (count_next == CNT_W'(LIMIT));
    end
  end

  assign saturated = sat_reg;

endmodule : starve_counter

// File: rtl/rf_write_sequencer.sv
// ---------------------------------------------------------------------------
// rf_write_sequencer
// Arbitrates the single register-file write port. After reset it sweeps every
// architectural register (value i into register i, one per cycle) while
// holding the pipeline busy; afterwards writeback requests win unconditionally
// and debug/loader writes take the idle cycles, with a freeze request raised
// if debug has waited too long.
// Ports:
//   clk  : clock, all state on posedge
//   rst  : asynchronous active-high reset
//   bus  : rf_write_sequencer_if.slave
//          in  wb_en/wb_dest/wb_val, dbg_valid/dbg_dest/dbg_val
//          out dbg_ready (combinational), rf_we/rf_dest/rf_val (registered),
//              busy, freeze (registered), wb_drop_err (sticky)
// ---------------------------------------------------------------------------
module rf_write_sequencer
  import rf_write_sequencer_pkg::*;
#(
  parameter int NUM_REGS     = RF_NUM_REGS,
  parameter int DATA_W       = RF_DATA_W,
  parameter int ADDR_W       = RF_ADDR_W,
  parameter int STARVE_LIMIT = RF_STARVE_LIMIT
) (
  input  logic clk,
  input  logic rst,
  rf_write_sequencer_if.slave bus
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  rf_seq_state_e     state_reg, state_next;
  logic [IDX_W-1:0]  idx_reg, idx_next;
  logic              rf_we_reg, rf_we_next;
  logic [ADDR_W-1:0] rf_dest_reg, rf_dest_next;
  logic [DATA_W-1:0] rf_val_reg, rf_val_next;
  logic              drop_reg, drop_next;

  logic              dbg_ready_c;
  logic              dbg_xfer_c;
  logic              starve_inc;
  logic              starve_clr;
  logic              starve_sat;

  // -------------------------------------------------------------------------
  // Next-state / write-port selection
  // -------------------------------------------------------------------------
  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    drop_next    = drop_reg;
    rf_we_next   = 1'b0;
    rf_dest_next = rf_dest_reg;   // data holds when nothing is written
    rf_val_next  = rf_val_reg;
    dbg_ready_c  = 1'b0;

    case (state_reg)
      SCRUB: begin
        rf_we_next   = 1'b1;
        rf_dest_next = ADDR_W'(idx_reg);
        rf_val_next  = DATA_W'(idx_reg);
        // The pipeline is held; a writeback now means upstream ignored busy.
        if (bus.wb_en) begin
          drop_next = 1'b1;
        end
        if (idx_reg == IDX_W'(NUM_REGS - 1)) begin
          state_next = RUN;
          idx_next   = '0;
        end else begin
          idx_next = idx_reg + IDX_W'(1);
        end
      end

      RUN: begin
        dbg_ready_c = ~bus.wb_en;
        if (bus.wb_en) begin
          rf_we_next   = 1'b1;
          rf_dest_next = bus.wb_dest;
          rf_val_next  = bus.wb_val;
        end else if (bus.dbg_valid) begin
          rf_we_next   = 1'b1;
          rf_dest_next = bus.dbg_dest;
          rf_val_next  = bus.dbg_val;
        end
      end

      default: begin
        state_next = SCRUB;
        idx_next   = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State and write-port registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= SCRUB;
      idx_reg     <= '0;
      rf_we_reg   <= 1'b0;
      rf_dest_reg <= '0;
      rf_val_reg  <= '0;
      drop_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      rf_we_reg   <= rf_we_next;
      rf_dest_reg <= rf_dest_next;
      rf_val_reg  <= rf_val_next;
      drop_reg    <= drop_next;
    end
  end

  // -------------------------------------------------------------------------
  // Debug starvation tracking: a waiting cycle is one in RUN where debug is
  // asking but writeback holds the port. Scrub cycles neither count nor clear.
  // -------------------------------------------------------------------------
  assign dbg_xfer_c = bus.dbg_valid & dbg_ready_c;
  assign starve_inc = (state_reg == RUN) & bus.dbg_valid & ~dbg_ready_c;
  assign starve_clr = ~bus.dbg_valid | dbg_xfer_c;

  starve_counter #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve_counter (
    .clk       (clk),
    .rst       (rst),
    .inc       (starve_inc),
    .clr       (starve_clr),
    .saturated (starve_sat)
  );

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.dbg_ready   = dbg_ready_c;
  assign bus.rf_we       = rf_we_reg;
  assign bus.rf_dest     = rf_dest_reg;
  assign bus.rf_val      = rf_val_reg;
  assign bus.busy        = (state_reg == SCRUB);
  assign bus.freeze      = starve_sat;
  assign bus.wb_drop_err = drop_reg;

endmodule : rf_write_sequencer

// File: tb/tb_rf_write_sequencer.sv
// ---------------------------------------------------------------------------
// tb_rf_write_sequencer
// Directed scenarios plus randomized traffic, every output compared each
// cycle against a cycle-level behavioural model of the sequencer.
// ---------------------------------------------------------------------------
module tb_rf_write_sequencer;

  localparam int NREGS = 15;
  localparam int LIMIT = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  rf_write_sequencer_if #(.ADDR_W(4), .DATA_W(32)) bus ();

  rf_write_sequencer #(
    .NUM_REGS     (NREGS),
    .DATA_W       (32),
    .ADDR_W       (4),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: what the write port and status should show right now.
  bit          m_scrub;
  int          m_idx;
  int          m_wait;
  bit          m_we;
  logic [3:0]  m_dest;
  logic [31:0] m_val;
  bit          m_freeze;
  bit          m_drop;
  bit          dbg_pend;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_scrub  = 1'b1;
    m_idx    = 0;
    m_wait   = 0;
    m_we     = 1'b0;
    m_dest   = '0;
    m_val    = '0;
    m_freeze = 1'b0;
    m_drop   = 1'b0;
  endtask

  // Apply one clock edge to the model using the inputs presented at it.
  task automatic model_edge();
    m_we = 1'b0;
    if (m_scrub) begin
      m_we   = 1'b1;
      m_dest = 4'(m_idx);
      m_val  = 32'(m_idx);
      if (bus.wb_en) m_drop = 1'b1;
      m_idx++;
      if (m_idx == NREGS) m_scrub = 1'b0;
    end else begin
      if (bus.wb_en) begin
        m_we = 1'b1; m_dest = bus.wb_dest; m_val = bus.wb_val;
      end else if (bus.dbg_valid) begin
        m_we = 1'b1; m_dest = bus.dbg_dest; m_val = bus.dbg_val;
      end
      // Debug waits only when it asks while writeback owns the port.
      if (bus.dbg_valid && bus.wb_en) m_wait = (m_wait < LIMIT) ? m_wait + 1 : LIMIT;
      else m_wait = 0;
    end
    m_freeze = (m_wait == LIMIT);
  endtask

  task automatic check_outputs();
    check("rf_we",       32'(bus.rf_we),       32'(m_we));
    check("rf_dest",     32'(bus.rf_dest),     32'(m_dest));
    check("rf_val",      bus.rf_val,           m_val);
    check("busy",        32'(bus.busy),        32'(m_scrub));
    check("freeze",      32'(bus.freeze),      32'(m_freeze));
    check("wb_drop_err", 32'(bus.wb_drop_err), 32'(m_drop));
    if (bus.rf_we)
      $display("write dest=%0d val=%08h busy=%0b freeze=%0b", bus.rf_dest, bus.rf_val, bus.busy, bus.freeze);
  endtask

  // One cycle: present inputs, check the combinational ready, clock, check.
  task automatic drive(input bit we, input logic [3:0] wd, input logic [31:0] wv,
                       input bit dv, input logic [3:0] dd, input logic [31:0] dval);
    bus.wb_en     = we;
    bus.wb_dest   = wd;
    bus.wb_val    = wv;
    bus.dbg_valid = dv;
    bus.dbg_dest  = dd;
    bus.dbg_val   = dval;
    #1;
    check("dbg_ready", 32'(bus.dbg_ready), 32'(!m_scrub && !we));
    dbg_pend = dv && (m_scrub || we);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
  endtask

  // Asynchronous reset applied between edges, held across one posedge.
  task automatic apply_reset();
    bus.wb_en = 1'b0; bus.dbg_valid = 1'b0;
    rst = 1'b1;
    #1;
    model_reset();
    dbg_pend = 1'b0;
    check_outputs();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0]  dd;
    logic [31:0] dval;
    bit          dv;

    bus.wb_en = 1'b0; bus.wb_dest = '0; bus.wb_val = '0;
    bus.dbg_valid = 1'b0; bus.dbg_dest = '0; bus.dbg_val = '0;
    dd = '0; dval = '0; dv = 1'b0;

    // Power-on reset, then a full idle scrub sweep.
    @(negedge clk);
    apply_reset();
    idle(NREGS + 2);

    // Simultaneous writeback and debug: writeback wins, debug follows.
    drive(1'b1, 4'd3, 32'hDEADBEEF, 1'b1, 4'd5, 32'd7);
    check("prio_wb_dest", 32'(bus.rf_dest), 32'd3);
    check("prio_wb_val",  bus.rf_val, 32'hDEADBEEF);
    drive(1'b0, 4'd0, 32'd0, 1'b1, 4'd5, 32'd7);
    check("dbg_after_dest", 32'(bus.rf_dest), 32'd5);
    check("dbg_after_val",  bus.rf_val, 32'd7);
    idle(2);

    // Ten writeback cycles starve a waiting debug request.
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 4'(k), 32'(k * 3 + 1), 1'b1, 4'd9, 32'h0000_0055);
      if (k == 6) check("freeze_early", 32'(bus.freeze), 32'd0);
      if (k == 7) check("freeze_at_limit", 32'(bus.freeze), 32'd1);
    end
    drive(1'b0, 4'd0, 32'd0, 1'b1, 4'd9, 32'h0000_0055);
    check("starved_dbg_dest", 32'(bus.rf_dest), 32'd9);
    check("freeze_cleared", 32'(bus.freeze), 32'd0);
    idle(2);

    // Randomized traffic; a pending debug request is held stable.
    for (int n = 0; n < 300; n++) begin
      if (!dbg_pend) begin
        dv   = ($urandom_range(0, 1) == 1);
        dd   = 4'($urandom_range(0, 15));
        dval = $urandom;
      end
      drive(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), $urandom, dv, dd, dval);
    end
    idle(2);

    // Writeback pulse during scrub cycle 4 is dropped and flagged.
    apply_reset();
    idle(4);
    drive(1'b1, 4'd2, 32'hCAFE_F00D, 1'b0, 4'd0, 32'd0);
    check("drop_no_wb_val", bus.rf_val, 32'd4);
    check("drop_flag", 32'(bus.wb_drop_err), 32'd1);
    idle(NREGS + 3);
    check("drop_sticky", 32'(bus.wb_drop_err), 32'd1);

    // Reset in the middle of the sweep restarts it from index 0.
    apply_reset();
    idle(7);
    #2;
    rst = 1'b1;
    #1;
    check("midreset_we",   32'(bus.rf_we),   32'd0);
    check("midreset_dest", 32'(bus.rf_dest), 32'd0);
    check("midreset_busy", 32'(bus.busy),    32'd1);
    check("midreset_drop", 32'(bus.wb_drop_err), 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(1);
    check("restart_idx0", 32'(bus.rf_dest), 32'd0);
    idle(NREGS + 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_rf_write_sequencer

// File: doc/rf_write_sequencer.md
RF_WRITE_SEQUENCER -- requirements
Module: rf_write_sequencer

Interface
REQ-001 Parameters SHALL be: NUM_REGS, 15, number of architectural registers swept by scrub.
REQ-002 DATA_W, 32, write-data width; ADDR_W, 4, register-index width; STARVE_LIMIT, 8, debug-wait cycles before freeze request.
REQ-003 Ports SHALL be as follows; one clock; reset is asynchronous and active-high:
- clk  in  1  single clock, all state on posedge.
- rst  in  1  asynchronous active-high reset.
- wb_en  in  1  writeback-stage write request.
- wb_dest  in  ADDR_W  writeback destination index.
- wb_val  in  DATA_W  writeback data.
- dbg_valid  in  1  debug/loader write request.
- dbg_dest  in  ADDR_W  debug destination index.
- dbg_val  in  DATA_W  debug data.
- dbg_ready  out  1  debug request accepted this cycle.
- rf_we  out  1  register-file write enable.
- rf_dest  out  ADDR_W  register-file write index.
- rf_val  out  DATA_W  register-file write data.
- busy  out  1  scrub in progress; pipeline held.
- freeze  out  1  pipeline-freeze request for debug starvation relief.
- wb_drop_err  out  1  sticky: writeback request arrived during scrub.

Function
REQ-004 FSM SHALL have states SCRUB and RUN; reset enters SCRUB with sweep index 0.
REQ-005 In SCRUB, each cycle SHALL issue one write of value i to register i, i = 0..NUM_REGS-1, then enter RUN the cycle after index NUM_REGS-1 is issued.
REQ-006 busy SHALL be 1 throughout SCRUB and 0 in RUN; scrub takes exactly NUM_REGS cycles.
REQ-007 In SCRUB, dbg_ready SHALL be 0 and any wb_en SHALL be discarded and set wb_drop_err (cleared only by reset).
REQ-008 In RUN, wb_en SHALL have strict priority: it is always accepted, never dropped.
REQ-009 dbg_ready SHALL be combinational: 1 iff state is RUN and wb_en is 0.
REQ-010 A debug transfer SHALL occur on a posedge where dbg_valid and dbg_ready are both 1; dbg_dest/dbg_val SHALL be held stable by the requester until then.
REQ-011 rf_we/rf_dest/rf_val SHALL be registered: an accepted request (WB, debug, or scrub) appears on the write port exactly one cycle after its accepting posedge, for one cycle.
REQ-012 rf_we SHALL be 0 in any cycle following one with no accepted request; rf_dest/rf_val then hold their previous values.
REQ-013 Starvation counter SHALL increment each RUN cycle with dbg_valid=1 and dbg_ready=0, clear on a debug transfer or dbg_valid=0, and saturate at STARVE_LIMIT.
REQ-014 freeze SHALL be registered, asserted while counter equals STARVE_LIMIT, and deasserted the cycle after the debug transfer completes.
REQ-015 Index values >= NUM_REGS SHALL be passed through unchanged; range checking is the register file's concern.
REQ-016 Simultaneous wb_en and dbg_valid in RUN SHALL grant WB; debug stays pending with no data loss.

Reset
REQ-017 Asserting rst at any time, including mid-scrub, SHALL immediately force state SCRUB, sweep index 0, counter 0, rf_we 0, rf_dest 0, rf_val 0, freeze 0, wb_drop_err 0, busy 1.
REQ-018 After rst deasserts, the first scrub write (index 0, value 0) SHALL appear on the write port one cycle after the first posedge.

Structure
REQ-019 A shared package SHALL hold the state enum (SCRUB, RUN) and the default DATA_W, ADDR_W, NUM_REGS constants used by the register file and this block.
REQ-020 The starvation counter SHALL be a sub-module named starve_counter (inc, clr, saturated flag); all else stays in one module.

Verification
REQ-021 Reset released, no requests -> rf_we high 15 consecutive cycles, rf_dest 0..14 with rf_val equal to rf_dest, busy falls after cycle 15.
REQ-022 RUN, wb_en with dest 3 val 0xDEADBEEF and dbg_valid dest 5 val 7 same cycle -> next cycle write 3/0xDEADBEEF, dbg_ready 0; debug writes 5/7 one cycle after wb_en drops.
REQ-023 RUN, wb_en held high 10 cycles with dbg_valid high -> freeze asserted after 8 waiting cycles; once wb_en drops, debug transfers and freeze clears next cycle.
REQ-024 wb_en pulse during scrub cycle 4 -> no WB write on port, wb_drop_err 1 and sticky until reset.
REQ-025 rst asserted at scrub index 7 -> outputs reset immediately; after release, sweep restarts at index 0 and completes all 15 writes.
